// File: rtl/uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_prog_loader
// Purpose  : UART byte command engine that writes/reads 18-bit program words.
// Revision : 1.0 - initial release
// ============================================================================
module uart_prog_loader #(
    parameter int ADDR_WIDTH   = 10,
    parameter int TIMEOUT_CLKS = 50000
) (
    input  logic                  clk_50M,
    input  logic                  reset,
    input  logic                  rx_dv,
    input  logic [7:0]            rx_byte,
    output logic                  tx_dv,
    output logic [7:0]            tx_byte,
    input  logic                  tx_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [17:0]           mem_wdata,
    output logic                  mem_we,
    input  logic [17:0]           mem_rdata,
    output logic                  cpu_hold
);

    localparam int c_TOUT_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [c_TOUT_W-1:0] c_TOUT_MAX = c_TOUT_W'(TIMEOUT_CLKS - 1);

    localparam logic [3:0] c_IDLE      = 4'd0;
    localparam logic [3:0] c_GET_ALO   = 4'd1;
    localparam logic [3:0] c_GET_AHI   = 4'd2;
    localparam logic [3:0] c_GET_CNT   = 4'd3;
    localparam logic [3:0] c_GET_W0    = 4'd4;
    localparam logic [3:0] c_GET_W1    = 4'd5;
    localparam logic [3:0] c_GET_W2    = 4'd6;
    localparam logic [3:0] c_WR        = 4'd7;
    localparam logic [3:0] c_RD_ADDR   = 4'd8;
    localparam logic [3:0] c_RD_WAIT   = 4'd9;
    localparam logic [3:0] c_SEND      = 4'd10;
    localparam logic [3:0] c_SEND_WAIT = 4'd11;
    localparam logic [3:0] c_ACK       = 4'd12;

    localparam logic [7:0] c_CMD_WRITE = 8'h01;
    localparam logic [7:0] c_CMD_READ  = 8'h02;
    localparam logic [7:0] c_CMD_PING  = 8'h03;
    localparam logic [7:0] c_RSP_PING  = 8'h18;
    localparam logic [7:0] c_RSP_ERR   = 8'hEE;
    localparam logic [7:0] c_RSP_ACK   = 8'hA5;

    // What SEND_WAIT does once the current byte has left the transmitter
    localparam logic [1:0] c_AFT_IDLE = 2'd0;
    localparam logic [1:0] c_AFT_READ = 2'd1;
    localparam logic [1:0] c_AFT_ACK  = 2'd2;

    logic [3:0]            r_state;
    logic                  r_is_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_alo;
    logic [7:0]            r_cnt;
    logic [17:0]           r_word;
    logic [7:0]            r_csum;
    logic [c_TOUT_W-1:0]   r_tout;
    logic [7:0]            r_tx_byte;
    logic                  r_cpu_hold;
    logic [1:0]            r_after;
    logic [1:0]            r_bidx;

    logic w_in_get;
    logic w_tout_hit;

    assign w_in_get   = (r_state >= c_GET_ALO) && (r_state <= c_GET_W2);
    assign w_tout_hit = w_in_get && !rx_dv && (r_tout == c_TOUT_MAX);

    assign tx_dv     = (r_state == c_SEND);
    assign mem_we    = (r_state == c_WR);
    assign tx_byte   = r_tx_byte;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_word;
    assign cpu_hold  = r_cpu_hold;

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_alo      <= '0;
            r_cnt      <= '0;
            r_word     <= '0;
            r_csum     <= '0;
            r_tout     <= '0;
            r_tx_byte  <= '0;
            r_cpu_hold <= 1'b0;
            r_after    <= c_AFT_IDLE;
            r_bidx     <= '0;
        end else begin
            // Inter-byte idle counter; a byte arriving on the expiry cycle wins
            if (!w_in_get || rx_dv) begin
                r_tout <= '0;
            end else begin
                r_tout <= r_tout + c_TOUT_W'(1);
            end

            if (w_tout_hit) begin
                r_tx_byte <= c_RSP_ERR;
                r_after   <= c_AFT_IDLE;
                r_state   <= c_SEND;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (rx_dv) begin
                            r_is_write <= (rx_byte == c_CMD_WRITE);
                            r_csum     <= '0;
                            r_after    <= c_AFT_IDLE;
                            case (rx_byte)
                                c_CMD_WRITE: begin
                                    r_cpu_hold <= 1'b1;
                                    r_state    <= c_GET_ALO;
                                end
                                c_CMD_READ: r_state <= c_GET_ALO;
                                c_CMD_PING: begin
                                    r_tx_byte <= c_RSP_PING;
                                    r_state   <= c_SEND;
                                end
                                default: begin
                                    r_tx_byte <= c_RSP_ERR;
                                    r_state   <= c_SEND;
                                end
                            endcase
                        end
                    end
                    c_GET_ALO: if (rx_dv) begin
                        r_alo   <= rx_byte;
                        r_state <= c_GET_AHI;
                    end
                    c_GET_AHI: if (rx_dv) begin
                        r_addr  <= ADDR_WIDTH'({rx_byte, r_alo});
                        r_state <= c_GET_CNT;
                    end
                    c_GET_CNT: if (rx_dv) begin
                        r_cnt   <= rx_byte;
                        r_state <= r_is_write ? c_GET_W0 : c_RD_ADDR;
                    end
                    c_GET_W0: if (rx_dv) begin
                        r_word[7:0] <= rx_byte;
                        r_state     <= c_GET_W1;
                    end
                    c_GET_W1: if (rx_dv) begin
                        r_word[15:8] <= rx_byte;
                        r_state      <= c_GET_W2;
                    end
                    c_GET_W2: if (rx_dv) begin
                        r_word[17:16] <= rx_byte[1:0];
                        r_state       <= c_WR;
                    end
                    c_WR: begin
                        // Only the low byte of each word contributes to the 8-bit XOR
                        r_csum <= r_csum ^ r_word[7:0];
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                        if (r_cnt == 8'd0) begin
                            r_tx_byte <= c_RSP_ACK;
                            r_after   <= c_AFT_ACK;
                            r_state   <= c_SEND;
                        end else begin
                            r_cnt   <= r_cnt - 8'd1;
                            r_state <= c_GET_W0;
                        end
                    end
                    c_RD_ADDR: r_state <= c_RD_WAIT;
                    c_RD_WAIT: begin
                        r_word    <= mem_rdata;
                        r_tx_byte <= mem_rdata[7:0];
                        r_bidx    <= 2'd0;
                        r_after   <= c_AFT_READ;
                        r_state   <= c_SEND;
                    end
                    c_SEND: r_state <= c_SEND_WAIT;
                    c_SEND_WAIT: if (tx_done) begin
                        case (r_after)
                            c_AFT_READ: begin
                                if (r_bidx == 2'd0) begin
                                    r_tx_byte <= r_word[15:8];
                                    r_bidx    <= 2'd1;
                                    r_state   <= c_SEND;
                                end else if (r_bidx == 2'd1) begin
                                    r_tx_byte <= {6'b0, r_word[17:16]};
                                    r_bidx    <= 2'd2;
                                    r_state   <= c_SEND;
                                end else if (r_cnt == 8'd0) begin
                                    r_state <= c_IDLE;
                                end else begin
                                    r_cnt   <= r_cnt - 8'd1;
                                    r_addr  <= r_addr + ADDR_WIDTH'(1);
                                    r_state <= c_RD_ADDR;
                                end
                            end
                            c_AFT_ACK: r_state <= c_ACK;
                            default: begin
                                r_cpu_hold <= 1'b0;
                                r_state    <= c_IDLE;
                            end
                        endcase
                    end
                    c_ACK: begin
                        r_tx_byte <= r_csum;
                        r_after   <= c_AFT_IDLE;
                        r_state   <= c_SEND;
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_prog_loader
// Purpose  : Scoreboard bench for uart_prog_loader with a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_prog_loader;

    localparam int AW   = 10;
    localparam int TOUT = 200;

    logic          clk_50M = 1'b0;
    logic          reset;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          tx_done = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [17:0]   mem_wdata;
    logic          mem_we;
    logic [17:0]   mem_rdata = '0;
    logic          cpu_hold;

    always #10 clk_50M = ~clk_50M;

    uart_prog_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CLKS(TOUT)) dut (
        .clk_50M  (clk_50M),
        .reset    (reset),
        .rx_dv    (rx_dv),
        .rx_byte  (rx_byte),
        .tx_dv    (tx_dv),
        .tx_byte  (tx_byte),
        .tx_done  (tx_done),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_rdata(mem_rdata),
        .cpu_hold (cpu_hold)
    );

    int total = 0;
    int bad   = 0;

    logic [8:0]  exp_tx[$];   // {cpu_hold expected, byte}
    logic [27:0] exp_wr[$];   // {addr, data}
    logic [17:0] ram[1024];
    logic [17:0] model_mem[1024];
    logic [17:0] wbuf[256];
    int          tx_cnt = 0;
    logic [7:0]  tx_held = '0;
    logic [8:0]  mon_tx;
    logic [27:0] mon_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Synchronous program RAM with one-clock read latency
    always @(posedge clk_50M) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Transmitter model plus output monitor
    always @(negedge clk_50M) begin
        tx_done = 1'b0;
        if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_done = 1'b1;
                chk("tx_byte_stable", 32'(tx_byte), 32'(tx_held));
            end
        end
        if (tx_dv) begin
            chk("tx_handshake_busy", 32'((tx_cnt > 0) || tx_done), 32'd0);
            tx_held = tx_byte;
            tx_cnt  = $urandom_range(3, 9);
            if (exp_tx.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_tx: got %02h expected none", tx_byte);
            end else begin
                mon_tx = exp_tx.pop_front();
                chk("tx_byte", 32'(tx_byte), 32'(mon_tx[7:0]));
                chk("tx_cpu_hold", 32'(cpu_hold), 32'(mon_tx[8]));
            end
        end
        if (mem_we) begin
            if (exp_wr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_we: got addr %0h data %0h expected none", mem_addr, mem_wdata);
            end else begin
                mon_wr = exp_wr.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(mon_wr[27:18]));
                chk("wr_data", 32'(mem_wdata), 32'(mon_wr[17:0]));
                chk("wr_cpu_hold", 32'(cpu_hold), 32'd1);
            end
        end
    end

    task automatic rx_send(input logic [7:0] b);
        @(negedge clk_50M);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk_50M);
        rx_dv   = 1'b0;
        rx_byte = 8'($urandom);
        repeat ($urandom_range(2, 10)) @(negedge clk_50M);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0 || tx_cnt != 0) && n < 5000) begin
            @(negedge clk_50M);
            n++;
        end
        if (n >= 5000) begin
            total++;
            bad++;
            $display("FAIL %s_stall: got %0d tx and %0d writes pending expected 0", name,
                     exp_tx.size(), exp_wr.size());
            exp_tx.delete();
            exp_wr.delete();
        end
        repeat (4) @(negedge clk_50M);
        chk({name, "_hold_idle"}, 32'(cpu_hold), 32'd0);
    endtask

    task automatic send_word(input logic [17:0] w);
        rx_send(w[7:0]);
        rx_send(w[15:8]);
        rx_send({6'($urandom), w[17:16]});
    endtask

    task automatic do_write(input logic [15:0] a, input int cnt);
        logic [AW-1:0] ad;
        logic [7:0]    cs = '0;
        for (int i = 0; i <= cnt; i++) begin
            ad = AW'(a + 16'(i));
            model_mem[ad] = wbuf[i];
            exp_wr.push_back({ad, wbuf[i]});
            cs = cs ^ wbuf[i][7:0];
        end
        exp_tx.push_back({1'b1, 8'hA5});
        exp_tx.push_back({1'b1, cs});
        rx_send(8'h01);
        rx_send(a[7:0]);
        rx_send(a[15:8]);
        rx_send(8'(cnt));
        for (int i = 0; i <= cnt; i++) send_word(wbuf[i]);
        wait_idle("write");
    endtask

    task automatic do_read(input logic [15:0] a, input int cnt);
        logic [17:0] w;
        for (int i = 0; i <= cnt; i++) begin
            w = model_mem[AW'(a + 16'(i))];
            exp_tx.push_back({1'b0, w[7:0]});
            exp_tx.push_back({1'b0, w[15:8]});
            exp_tx.push_back({1'b0, 6'b0, w[17:16]});
        end
        rx_send(8'h02);
        rx_send(a[7:0]);
        rx_send(a[15:8]);
        rx_send(8'(cnt));
        wait_idle("read");
    endtask

    task automatic do_single(input logic [7:0] cmd, input logic [7:0] rsp, input string name);
        exp_tx.push_back({1'b0, rsp});
        rx_send(cmd);
        wait_idle(name);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_tx_dv"}, 32'(tx_dv), 32'd0);
        chk({name, "_tx_byte"}, 32'(tx_byte), 32'd0);
        chk({name, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({name, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({name, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    endtask

    initial begin
        #1800000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] last_addr = 16'h0010;
        int          last_cnt  = 1;
        logic [7:0]  c;
        for (int i = 0; i < 1024; i++) begin
            ram[i]       = '0;
            model_mem[i] = '0;
        end
        reset   = 1'b1;
        rx_dv   = 1'b0;
        rx_byte = '0;
        repeat (3) @(negedge clk_50M);
        chk_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk_50M);

        do_single(8'h03, 8'h18, "ping");

        wbuf[0] = 18'h3FFFF;
        wbuf[1] = 18'h00001;
        do_write(16'h0010, 1);
        do_read(16'h0010, 1);

        // Address wrap and dropped upper address bits
        wbuf[0] = 18'h2ABCD;
        wbuf[1] = 18'h1C3E5;
        do_write(16'h03FF, 1);
        do_read(16'h03FF, 1);
        wbuf[0] = 18'h15A5A;
        do_write(16'hFC05, 0);
        do_read(16'h0005, 0);

        do_single(8'h7F, 8'hEE, "unknown");

        // Timeout after two header bytes of a WRITE
        exp_tx.push_back({1'b1, 8'hEE});
        rx_send(8'h01);
        rx_send(8'h10);
        wait_idle("timeout_hdr");

        // Timeout mid-payload keeps the first word written
        model_mem[AW'(16'h0020)] = 18'h0BEEF;
        exp_wr.push_back({AW'(16'h0020), 18'h0BEEF});
        exp_tx.push_back({1'b1, 8'hEE});
        rx_send(8'h01);
        rx_send(8'h20);
        rx_send(8'h00);
        rx_send(8'h01);
        send_word(18'h0BEEF);
        wait_idle("timeout_data");
        do_read(16'h0020, 0);

        exp_tx.push_back({1'b0, 8'hEE});
        rx_send(8'h02);
        wait_idle("timeout_read");

        // Reset in the middle of a WRITE word
        rx_send(8'h01);
        rx_send(8'h23);
        rx_send(8'h01);
        rx_send(8'h00);
        rx_send(8'h5A);
        chk("pre_reset_hold", 32'(cpu_hold), 32'd1);
        @(negedge clk_50M);
        reset = 1'b1;
        @(negedge clk_50M);
        chk_all_zero("mid_reset");
        reset = 1'b0;
        do_single(8'h03, 8'h18, "ping_after_reset");

        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 3))
                0: do_single(8'h03, 8'h18, "rnd_ping");
                1: begin
                    last_addr = 16'($urandom);
                    last_cnt  = $urandom_range(0, 5);
                    for (int i = 0; i <= last_cnt; i++) wbuf[i] = 18'($urandom);
                    do_write(last_addr, last_cnt);
                end
                2: begin
                    if ($urandom_range(0, 1) == 0) do_read(last_addr, last_cnt);
                    else do_read(16'($urandom), $urandom_range(0, 3));
                end
                default: begin
                    c = 8'($urandom);
                    while (c >= 8'h01 && c <= 8'h03) c = 8'($urandom);
                    do_single(c, 8'hEE, "rnd_unknown");
                end
            endcase
        end

        repeat (5) @(negedge clk_50M);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
